// File: rtl/nvram_pkg.sv
// Shared definitions for the NVRAM store controller: state encoding and
// default timing constants.
package nvram_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENABLE  = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int DEF_CLKDIV    = 4;
    localparam int DEF_SETTLE    = 8;
    localparam int DEF_START_LEN = 4;
    localparam int DEF_TIMEOUT   = 65535;
    localparam int CNT_W         = 16;

    // A phase lasting n cycles is loaded with n-1 and ends when the counter hits 0.
    function automatic logic [CNT_W-1:0] dur_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/nvram_sync.sv
// Two-flop synchronizer for the asynchronous charge-pump busy flag.
module nvram_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nvram_store_ctrl.sv
// NVRAM store sequencer: enables the selected memories, pulses the charge-pump
// start and waits for its busy handshake, with timeouts on both busy edges.
module nvram_store_ctrl
    import nvram_pkg::*;
#(
    parameter int CLKDIV    = DEF_CLKDIV,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int START_LEN = DEF_START_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        store_req,
    input  logic [1:0]  store_sel,
    input  logic [15:0] trim_in,
    output logic        store_ack,
    output logic        store_done,
    output logic        store_err,
    output logic        busy,
    output logic        cp_por,
    output logic        cp_clki,
    output logic        cp_vsestart,
    output logic        cp_busynvc,
    output logic        cp_mem1_ent,
    output logic        cp_mem2_ent,
    output logic [15:0] cp_trim,
    input  logic        cp_vsebusy
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic [1:0]       sel_q;
    logic [15:0]      trim_q;
    logic [7:0]       div_cnt;
    logic             busy_s;
    logic             accept, err_set, cnt_zero, ent_phase;

    nvram_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (cp_vsebusy),
        .q      (busy_s)
    );

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        err_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (store_req) begin
                    if (store_sel != 2'b00) begin
                        accept   = 1'b1;
                        state_nx = S_ENABLE;
                    end else begin
                        err_set  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            S_ENABLE:  if (cnt_zero) state_nx = S_START;
            S_START:   if (cnt_zero) state_nx = S_WAIT_HI;
            S_WAIT_HI: begin
                if (busy_s) begin
                    state_nx = S_WAIT_LO;
                end else if (cnt_zero) begin
                    err_set  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_WAIT_LO: begin
                if (!busy_s) begin
                    state_nx = S_DONE;
                end else if (cnt_zero) begin
                    err_set  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // The shared counter is reloaded for whichever state is being entered.
    always_comb begin
        cnt_load = '0;
        case (state_nx)
            S_ENABLE:             cnt_load = dur_load(SETTLE);
            S_START:              cnt_load = dur_load(START_LEN);
            S_WAIT_HI, S_WAIT_LO: cnt_load = dur_load(TIMEOUT);
            default:              cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sel_q     <= 2'b00;
            trim_q    <= 16'h0000;
            store_err <= 1'b0;
            store_ack <= 1'b0;
        end else begin
            state     <= state_nx;
            store_ack <= accept;
            if (state_nx != state)
                cnt <= cnt_load;
            else if (!cnt_zero)
                cnt <= cnt - 1'b1;
            if (accept) begin
                sel_q  <= store_sel;
                trim_q <= trim_in;
            end
            if (accept)
                store_err <= 1'b0;
            else if (err_set)
                store_err <= 1'b1;
        end
    end

    // Pump clock runs whenever the pump is out of power-on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cp_por  <= 1'b1;
            cp_clki <= 1'b0;
            div_cnt <= 8'd0;
        end else begin
            cp_por <= 1'b0;
            if (cp_por) begin
                cp_clki <= 1'b0;
                div_cnt <= 8'd0;
            end else if (div_cnt == 8'(CLKDIV - 1)) begin
                cp_clki <= ~cp_clki;
                div_cnt <= 8'd0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    assign ent_phase   = (state == S_ENABLE) || (state == S_START) ||
                         (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign cp_busynvc  = ent_phase;
    assign cp_mem1_ent = ent_phase & sel_q[0];
    assign cp_mem2_ent = ent_phase & sel_q[1];
    assign cp_vsestart = (state == S_START);
    assign store_done  = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign cp_trim     = trim_q;

endmodule

// File: tb/tb_nvram_store_ctrl.sv
// Bench for nvram_store_ctrl: table rows, random sequences against a waveform
// model of the pump handshake, and hand-written reset / back-to-back cases.
module tb_nvram_store_ctrl;

    localparam int TC = 4;   // CLKDIV
    localparam int TS = 8;   // SETTLE
    localparam int TL = 4;   // START_LEN
    localparam int TT = 50;  // TIMEOUT

    logic        clk = 1'b0;
    logic        resetn, store_req, cp_vsebusy;
    logic [1:0]  store_sel;
    logic [15:0] trim_in;
    logic        store_ack, store_done, store_err, busy;
    logic        cp_por, cp_clki, cp_vsestart, cp_busynvc, cp_mem1_ent, cp_mem2_ent;
    logic [15:0] cp_trim;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    nvram_store_ctrl #(.CLKDIV(TC), .SETTLE(TS), .START_LEN(TL), .TIMEOUT(TT)) dut (
        .clk(clk), .resetn(resetn), .store_req(store_req), .store_sel(store_sel),
        .trim_in(trim_in), .store_ack(store_ack), .store_done(store_done),
        .store_err(store_err), .busy(busy), .cp_por(cp_por), .cp_clki(cp_clki),
        .cp_vsestart(cp_vsestart), .cp_busynvc(cp_busynvc), .cp_mem1_ent(cp_mem1_ent),
        .cp_mem2_ent(cp_mem2_ent), .cp_trim(cp_trim), .cp_vsebusy(cp_vsebusy)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] trim;
        int          bs;
        int          bl;
        int          exp_d;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int   d;
        int   ack_n;
        int   ack_cnt;
        int   vs_first;
        int   vs_cnt;
        int   ent_cnt;
        int   ent_at_done;
        int   ent_wrong;
        int   trim_bad;
        logic err;
        logic busy_after;
    } meas_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // Pump busy as seen at the input on edge k after acceptance.
    function automatic bit raw(input int k, input int bs, input int bl);
        return (k >= bs) && (k < bs + bl);
    endfunction

    // Busy reaches the sequencer two edges after it is sampled; each wait
    // phase spans TIMEOUT edges starting one edge after its entry.
    function automatic void model(input int bs, input int bl, output int d, output logic err);
        int w, h;
        w = TS + TL;
        h = -1;
        d = w + TT;
        err = 1'b1;
        for (int n = w + 1; n <= w + TT; n++)
            if (raw(n - 2, bs, bl)) begin h = n; break; end
        if (h >= 0) begin
            d = h + TT;
            for (int n = h + 1; n <= h + TT; n++)
                if (!raw(n - 2, bs, bl)) begin d = n; err = 1'b0; break; end
        end
    endfunction

    task automatic run_seq(input logic [1:0] sel, input logic [15:0] trim,
                           input int bs, input int bl, output meas_t m);
        logic [1:0] ent;
        m = '{d: -1, ack_n: -1, ack_cnt: 0, vs_first: -1, vs_cnt: 0, ent_cnt: 0,
              ent_at_done: -1, ent_wrong: 0, trim_bad: 0, err: 1'bx, busy_after: 1'bx};
        store_req  = 1'b1;
        store_sel  = sel;
        trim_in    = trim;
        cp_vsebusy = 1'b0;
        @(posedge clk); #1;
        store_req = 1'b0;
        trim_in   = ~trim;
        for (int n = 0; n < 400; n++) begin
            ent = {cp_mem2_ent, cp_mem1_ent};
            if (store_ack) begin m.ack_cnt++; m.ack_n = n; end
            if (cp_vsestart) begin
                m.vs_cnt++;
                if (m.vs_first < 0) m.vs_first = n;
            end
            if (cp_busynvc) m.ent_cnt++;
            if (ent != (cp_busynvc ? sel : 2'b00)) m.ent_wrong++;
            if (m.ack_cnt > 0 && cp_trim != trim) m.trim_bad++;
            if (store_done) begin
                m.d = n;
                m.err = store_err;
                m.ent_at_done = int'(cp_busynvc | cp_mem1_ent | cp_mem2_ent);
                break;
            end
            cp_vsebusy = raw(n + 1, bs, bl);
            @(posedge clk); #1;
        end
        cp_vsebusy = 1'b0;
        @(posedge clk); #1;
        m.busy_after = busy;
    endtask

    task automatic check_seq(input string nm, input logic [1:0] sel, input meas_t m,
                             input int exp_d, input logic exp_err);
        chk({nm, " done_edge"}, m.d, exp_d);
        chk({nm, " store_err"}, int'(m.err), int'(exp_err));
        chk({nm, " ent_at_done"}, m.ent_at_done, 0);
        chk({nm, " ent_sel"}, m.ent_wrong, 0);
        chk({nm, " idle_after"}, int'(m.busy_after), 0);
        if (sel == 2'b00) begin
            chk({nm, " ack_cnt"}, m.ack_cnt, 0);
            chk({nm, " vs_cnt"}, m.vs_cnt, 0);
            chk({nm, " ent_cnt"}, m.ent_cnt, 0);
        end else begin
            chk({nm, " ack_cnt"}, m.ack_cnt, 1);
            chk({nm, " ack_edge"}, m.ack_n, 0);
            chk({nm, " vs_first"}, m.vs_first, TS);
            chk({nm, " vs_cnt"}, m.vs_cnt, TL);
            chk({nm, " ent_cnt"}, m.ent_cnt, exp_d);
            chk({nm, " trim_hold"}, m.trim_bad, 0);
        end
    endtask

    initial begin
        vec_t  vecs[9];
        meas_t m;
        int    d_mod;
        logic  e_mod;
        int    acks[$], dones[$], toggles[$];
        logic  prev_clki;
        int    late_done;

        // sel, trim, busy start, busy length, expected done edge, expected err
        vecs[0] = '{2'b01, 16'hA5C3, 18,  30, 50, 1'b0}; // normal handshake
        vecs[1] = '{2'b01, 16'h1234, 18,   0, 62, 1'b1}; // busy never rises
        vecs[2] = '{2'b10, 16'h0F0F, 18, 200, 70, 1'b1}; // busy stuck high
        vecs[3] = '{2'b11, 16'h8001,  2,   3, 62, 1'b1}; // pulse during ENABLE ignored
        vecs[4] = '{2'b10, 16'h7777, 11,   5, 18, 1'b0}; // earliest visible busy
        vecs[5] = '{2'b11, 16'hBEEF, 10,   1, 62, 1'b1}; // pulse seen in START ignored
        vecs[6] = '{2'b01, 16'hCAFE, 11,   1, 14, 1'b0}; // one-cycle busy
        vecs[7] = '{2'b01, 16'h5555, 60,   5, 67, 1'b0}; // busy on last WAIT_HI cycle
        vecs[8] = '{2'b10, 16'hAAAA, 61,   5, 62, 1'b1}; // busy one cycle too late

        resetn = 1'b0; store_req = 1'b0; store_sel = 2'b00; trim_in = 16'h0; cp_vsebusy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst cp_por", int'(cp_por), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst outs", int'({store_ack, store_done, store_err, cp_clki, cp_vsestart,
                              cp_busynvc, cp_mem1_ent, cp_mem2_ent}), 0);
        chk("rst cp_trim", int'(cp_trim), 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("por release", int'(cp_por), 0);

        foreach (vecs[i]) begin
            run_seq(vecs[i].sel, vecs[i].trim, vecs[i].bs, vecs[i].bl, m);
            check_seq($sformatf("vec%0d", i), vecs[i].sel, m, vecs[i].exp_d, vecs[i].exp_err);
        end

        // Empty select: immediate error completion, flag sticky until next accept.
        run_seq(2'b00, 16'h4321, 1, 5, m);
        check_seq("sel0", 2'b00, m, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sel0 err sticky", int'(store_err), 1);
        store_req = 1'b1; store_sel = 2'b01; trim_in = 16'h0101;
        @(posedge clk); #1;
        chk("err cleared on ack", int'(store_err), 0);
        chk("ack after err", int'(store_ack), 1);
        store_req = 1'b0;
        late_done = -1;
        for (int n = 0; n < 200; n++) begin
            if (store_done) begin late_done = n; break; end
            @(posedge clk); #1;
        end
        chk("clear seq done", late_done, TS + TL + TT);
        @(posedge clk); #1;

        // Random sequences against the pump-waveform model.
        for (int i = 0; i < 12; i++) begin
            logic [1:0] s;
            int bs, bl;
            s  = 2'($urandom_range(1, 3));
            bs = $urandom_range(1, 70);
            bl = $urandom_range(0, 80);
            model(bs, bl, d_mod, e_mod);
            run_seq(s, 16'($urandom), bs, bl, m);
            check_seq($sformatf("rnd%0d", i), s, m, d_mod, e_mod);
        end

        // Request held through DONE restarts only after returning to IDLE.
        store_req = 1'b1; store_sel = 2'b01; trim_in = 16'h2468;
        @(posedge clk); #1;
        for (int n = 0; n < 200; n++) begin
            if (store_ack) acks.push_back(n);
            if (store_done) dones.push_back(n);
            if (acks.size() == 2) store_req = 1'b0;
            if (dones.size() == 2) break;
            cp_vsebusy = raw(n + 1, 11, 1);
            @(posedge clk); #1;
        end
        store_req = 1'b0; cp_vsebusy = 1'b0;
        chk("held ack count", acks.size(), 2);
        chk("held done count", dones.size(), 2);
        if (acks.size() == 2 && dones.size() == 2) begin
            chk("held ack0", acks[0], 0);
            chk("held done0", dones[0], 14);
            chk("held ack1", acks[1], 16);
            chk("held done1", dones[1], 16 + TS + TL + TT);
        end
        @(posedge clk); #1;

        // Reset in WAIT_LO aborts at once; trim latched at acceptance.
        store_req = 1'b1; store_sel = 2'b01; trim_in = 16'h9ABC;
        @(posedge clk); #1;
        store_req = 1'b0; trim_in = 16'h1111;
        for (int n = 0; n < 30; n++) begin
            if (n == 5) chk("trim held", int'(cp_trim), 16'h9ABC);
            cp_vsebusy = raw(n + 1, 18, 200);
            @(posedge clk); #1;
        end
        chk("mid busynvc", int'(cp_busynvc), 1);
        chk("mid mem1", int'(cp_mem1_ent), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort cp_por", int'(cp_por), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort outs", int'({store_ack, store_done, store_err, cp_clki, cp_vsestart,
                                cp_busynvc, cp_mem1_ent, cp_mem2_ent}), 0);
        chk("abort cp_trim", int'(cp_trim), 0);
        resetn = 1'b1; cp_vsebusy = 1'b0;
        @(posedge clk); #1;
        chk("abort por release", int'(cp_por), 0);
        late_done = 0;
        prev_clki = cp_clki;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (store_done) late_done++;
            if (cp_clki != prev_clki) toggles.push_back(n);
            prev_clki = cp_clki;
        end
        chk("no done after abort", late_done, 0);
        chk("clki toggles", (toggles.size() >= 8) ? 1 : 0, 1);
        for (int i = 1; i < toggles.size(); i++)
            chk($sformatf("clki period%0d", i), toggles[i] - toggles[i-1], TC);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
